// File: rtl/banked_rf.sv
// banked_rf: multi-bank warp register file for the operand collector.
// Each bank has one read port and one write port. Writes are lane-masked
// and write-first, so a read of the entry being written returns the merged
// value. Reads carry a collector tag and a valid flag. An optional output
// register adds one cycle of latency. After reset, a small state machine
// zeroes every entry before any traffic is accepted.
//
// state | meaning
// CLEAR | zeroing entry clr_ptr of every bank; user reads and writes ignored
// RUN   | normal operation; left only through reset
module banked_rf #(
  parameter int NUM_BANKS = 4,
  parameter int DATA      = 256,
  parameter int ADDR      = 3,
  parameter int OCID_W    = 3,
  parameter int OREG      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BANKS-1:0]          rd_valid,
  input  logic [NUM_BANKS*ADDR-1:0]     rd_addr,
  input  logic [NUM_BANKS*OCID_W-1:0]   rd_ocid,
  output logic [NUM_BANKS-1:0]          rd_ready,
  output logic [NUM_BANKS*DATA-1:0]     rd_dout,
  output logic [NUM_BANKS-1:0]          rd_dout_valid,
  output logic [NUM_BANKS*OCID_W-1:0]   rd_dout_ocid,
  input  logic [NUM_BANKS-1:0]          wr_en,
  input  logic [NUM_BANKS*ADDR-1:0]     wr_addr,
  input  logic [NUM_BANKS*DATA-1:0]     wr_din,
  input  logic [NUM_BANKS*(DATA/32)-1:0] wr_mask,
  output logic                          init_done
);
  localparam int LANES = DATA / 32;
  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [ADDR-1:0]             clr_ptr;
  logic                        clr_active;
  logic [DATA-1:0]             mem [NUM_BANKS][DEPTH];
  logic [NUM_BANKS*DATA-1:0]   rd_fwd;
  logic [NUM_BANKS-1:0]        rd_acc;
  logic [NUM_BANKS*DATA-1:0]   s1_data;
  logic [NUM_BANKS-1:0]        s1_valid;
  logic [NUM_BANKS*OCID_W-1:0] s1_ocid;

  // State register; the clear pointer walks every entry while clearing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + ADDR'(1);
    end
  end

  // Next state: leave CLEAR once the last entry is being written.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_ptr == ADDR'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  // State-decoded controls.
  always_comb begin
    clr_active = (state == ST_CLEAR);
    init_done  = (state == ST_RUN);
  end

  assign rd_ready = {NUM_BANKS{init_done}};
  assign rd_acc   = rd_valid & rd_ready;

  // Read data with write-first bypass of the lanes written this cycle.
  always_comb begin
    rd_fwd = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_fwd[b*DATA +: DATA] = mem[b][rd_addr[b*ADDR +: ADDR]];
      if (init_done && wr_en[b] &&
          (wr_addr[b*ADDR +: ADDR] == rd_addr[b*ADDR +: ADDR])) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_mask[b*LANES + l])
            rd_fwd[b*DATA + l*32 +: 32] = wr_din[b*DATA + l*32 +: 32];
        end
      end
    end
  end

  // Storage: clear sweep during CLEAR, lane-masked user writes during RUN.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst_n && clr_active) begin
        mem[b][clr_ptr] <= '0;
      end else if (rst_n && init_done && wr_en[b]) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_mask[b*LANES + l])
            mem[b][wr_addr[b*ADDR +: ADDR]][l*32 +: 32] <= wr_din[b*DATA + l*32 +: 32];
        end
      end
    end
  end

  // First read stage: capture data and tag on accept, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= '0;
      s1_ocid  <= '0;
    end else begin
      s1_valid <= rd_acc;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_acc[b]) begin
          s1_data[b*DATA +: DATA]     <= rd_fwd[b*DATA +: DATA];
          s1_ocid[b*OCID_W +: OCID_W] <= rd_ocid[b*OCID_W +: OCID_W];
        end
      end
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [NUM_BANKS*DATA-1:0]   s2_data;
    logic [NUM_BANKS-1:0]        s2_valid;
    logic [NUM_BANKS*OCID_W-1:0] s2_ocid;

    // Output register: forwards only valid beats so idle outputs hold.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= '0;
        s2_ocid  <= '0;
      end else begin
        s2_valid <= s1_valid;
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (s1_valid[b]) begin
            s2_data[b*DATA +: DATA]     <= s1_data[b*DATA +: DATA];
            s2_ocid[b*OCID_W +: OCID_W] <= s1_ocid[b*OCID_W +: OCID_W];
          end
        end
      end
    end

    assign rd_dout       = s2_data;
    assign rd_dout_valid = s2_valid;
    assign rd_dout_ocid  = s2_ocid;
  end else begin : g_noreg
    assign rd_dout       = s1_data;
    assign rd_dout_valid = s1_valid;
    assign rd_dout_ocid  = s1_ocid;
  end

endmodule

// File: tb/tb_banked_rf.sv
// Bench for banked_rf: one instance per read latency, driven in lockstep.
module tb_banked_rf;
  localparam int NB = 4, DW = 256, AW = 3, OW = 3, LN = 8, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NB-1:0]      rd_valid, wr_en;
  logic [NB*AW-1:0]   rd_addr, wr_addr;
  logic [NB*OW-1:0]   rd_ocid;
  logic [NB*DW-1:0]   wr_din;
  logic [NB*LN-1:0]   wr_mask;

  logic [NB-1:0]      rdy0, dv0, rdy1, dv1;
  logic [NB*DW-1:0]   dout0, dout1;
  logic [NB*OW-1:0]   docid0, docid1;
  logic               done0, done1;

  banked_rf #(.NUM_BANKS(NB), .DATA(DW), .ADDR(AW), .OCID_W(OW), .OREG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ocid(rd_ocid),
    .rd_ready(rdy0), .rd_dout(dout0), .rd_dout_valid(dv0), .rd_dout_ocid(docid0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_mask(wr_mask), .init_done(done0));

  banked_rf #(.NUM_BANKS(NB), .DATA(DW), .ADDR(AW), .OCID_W(OW), .OREG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ocid(rd_ocid),
    .rd_ready(rdy1), .rd_dout(dout1), .rd_dout_valid(dv1), .rd_dout_ocid(docid1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_mask(wr_mask), .init_done(done1));

  // Reference model: plain storage, a clear countdown, and expected outputs.
  logic [DW-1:0] mm [NB][DEPTH];
  int            clr_left;
  logic [NB-1:0] e0v, e1v, sv;
  logic [DW-1:0] e0d [NB], e1d [NB], sd [NB];
  logic [OW-1:0] e0o [NB], e1o [NB], so [NB];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            bank;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wword;
    logic [LN-1:0] wmask;
    logic          re;
    logic [AW-1:0] ra;
    logic [OW-1:0] oc;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [DW-1:0] rep(input logic [31:0] w);
    return {LN{w}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rd_valid = '0; rd_addr = '0; rd_ocid = '0;
    wr_en = '0; wr_addr = '0; wr_din = '0; wr_mask = '0;
  endtask

  task automatic check_all();
    chk("init_done0", DW'(done0), DW'(clr_left == 0));
    chk("init_done1", DW'(done1), DW'(clr_left == 0));
    chk("rd_ready0", DW'(rdy0), DW'({NB{clr_left == 0}}));
    chk("rd_ready1", DW'(rdy1), DW'({NB{clr_left == 0}}));
    chk("valid0", DW'(dv0), DW'(e0v));
    chk("valid1", DW'(dv1), DW'(e1v));
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("dout0_b%0d", b), dout0[b*DW +: DW], e0d[b]);
      chk($sformatf("ocid0_b%0d", b), DW'(docid0[b*OW +: OW]), DW'(e0o[b]));
      chk($sformatf("dout1_b%0d", b), dout1[b*DW +: DW], e1d[b]);
      chk($sformatf("ocid1_b%0d", b), DW'(docid1[b*OW +: OW]), DW'(e1o[b]));
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    logic [NB-1:0] acc;
    logic [DW-1:0] rv [NB];
    logic [AW-1:0] ra, wa;
    acc = '0;
    for (int b = 0; b < NB; b++) rv[b] = '0;
    if (!rst_n) begin
      clr_left = DEPTH;
      e0v = '0; e1v = '0; sv = '0;
      for (int b = 0; b < NB; b++) begin
        e0d[b] = '0; e1d[b] = '0; sd[b] = '0;
        e0o[b] = '0; e1o[b] = '0; so[b] = '0;
        for (int a = 0; a < DEPTH; a++) mm[b][a] = '0;
      end
    end else begin
      if (clr_left != 0) begin
        clr_left--;
      end else begin
        for (int b = 0; b < NB; b++) begin
          ra = rd_addr[b*AW +: AW];
          wa = wr_addr[b*AW +: AW];
          acc[b] = rd_valid[b];
          if (wr_en[b])
            for (int l = 0; l < LN; l++)
              if (wr_mask[b*LN + l]) mm[b][wa][l*32 +: 32] = wr_din[b*DW + l*32 +: 32];
          rv[b] = mm[b][ra];
        end
      end
      for (int b = 0; b < NB; b++) begin
        e1v[b] = sv[b];
        if (sv[b]) begin e1d[b] = sd[b]; e1o[b] = so[b]; end
        sv[b] = acc[b];
        if (acc[b]) begin sd[b] = rv[b]; so[b] = rd_ocid[b*OW +: OW]; end
        e0v[b] = acc[b];
        if (acc[b]) begin e0d[b] = rv[b]; e0o[b] = rd_ocid[b*OW +: OW]; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!done0 && n < 20) begin
      step();
      n++;
    end
    chk(nm, DW'(n), DW'(DEPTH));
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      rd_valid = '1;
      for (int b = 0; b < NB; b++) begin
        rd_addr[b*AW +: AW] = AW'(a);
        rd_ocid[b*OW +: OW] = OW'(a);
      end
      step();
      chk({nm, "_valid"}, DW'(dv0), DW'({NB{1'b1}}));
      for (int b = 0; b < NB; b++) chk(nm, dout0[b*DW +: DW], '0);
    end
    idle();
    step();
  endtask

  function automatic vec_t mk(int bank, logic we, int wa, logic [31:0] ww, logic [LN-1:0] wm,
                              logic re, int ra, int oc, logic ev, logic [DW-1:0] ed);
    vec_t v;
    v.bank = bank; v.we = we; v.wa = AW'(wa); v.wword = ww; v.wmask = wm;
    v.re = re; v.ra = AW'(ra); v.oc = OW'(oc); v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] lane02;
    lane02 = {{5{32'hFFFF_FFFF}}, 32'h0, 32'hFFFF_FFFF, 32'h0};
    tbl[0] = mk(2, 1, 5, 32'hA5A5_A5A5, 8'hFF, 0, 0, 0, 0, '0);
    tbl[1] = mk(2, 0, 0, 32'h0,         8'h00, 1, 5, 3, 1, rep(32'hA5A5_A5A5));
    tbl[2] = mk(1, 1, 0, 32'hFFFF_FFFF, 8'hFF, 0, 0, 0, 0, '0);
    tbl[3] = mk(1, 1, 0, 32'h0,         8'h05, 1, 0, 6, 1, lane02);
    tbl[4] = mk(1, 0, 0, 32'h0,         8'h00, 1, 0, 1, 1, lane02);
    tbl[5] = mk(3, 1, 7, 32'h1234_5678, 8'h00, 1, 7, 2, 1, '0);
    tbl[6] = mk(0, 1, 2, 32'hDEAD_BEEF, 8'hF0, 1, 3, 4, 1, '0);
    tbl[7] = mk(0, 0, 0, 32'h0,         8'h00, 1, 2, 5, 1, {{4{32'hDEAD_BEEF}}, 128'h0});

    // Reset, then init timing and an all-zero sweep.
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_init("init_cycles");
    read_all_zero("post_reset_zero");

    // Directed vectors on the single-cycle instance.
    for (int i = 0; i < 8; i++) begin
      idle();
      wr_en[tbl[i].bank] = tbl[i].we;
      wr_addr[tbl[i].bank*AW +: AW] = tbl[i].wa;
      wr_din[tbl[i].bank*DW +: DW] = rep(tbl[i].wword);
      wr_mask[tbl[i].bank*LN +: LN] = tbl[i].wmask;
      rd_valid[tbl[i].bank] = tbl[i].re;
      rd_addr[tbl[i].bank*AW +: AW] = tbl[i].ra;
      rd_ocid[tbl[i].bank*OW +: OW] = tbl[i].oc;
      step();
      chk($sformatf("tbl%0d_valid", i), DW'(dv0[tbl[i].bank]), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), dout0[tbl[i].bank*DW +: DW], tbl[i].ed);
        chk($sformatf("tbl%0d_ocid", i), DW'(docid0[tbl[i].bank*OW +: OW]), DW'(tbl[i].oc));
      end
    end
    idle();
    step();

    // Two-cycle pipeline: back-to-back reads with a write behind addr1.
    for (int i = 0; i < 8; i++) begin
      idle();
      wr_en[0] = 1'b1;
      wr_addr[0 +: AW] = AW'(i);
      wr_din[0 +: DW] = rep(32'h1000_0000 + 32'(i));
      wr_mask[0 +: LN] = '1;
      step();
    end
    idle();
    step();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) begin
        rd_valid[0] = 1'b1;
        rd_addr[0 +: AW] = AW'(i);
        rd_ocid[0 +: OW] = OW'(i);
      end
      if (i == 2) begin
        wr_en[0] = 1'b1;
        wr_addr[0 +: AW] = AW'(1);
        wr_din[0 +: DW] = rep(32'hFFFF_FFFF);
        wr_mask[0 +: LN] = '1;
      end
      step();
      if (i >= 1 && i <= 8) begin
        chk("pipe_valid", DW'(dv1[0]), DW'(1'b1));
        chk("pipe_ocid", DW'(docid1[0 +: OW]), DW'(i - 1));
        chk("pipe_data", dout1[0 +: DW], rep(32'h1000_0000 + 32'(i - 1)));
      end else begin
        chk("pipe_idle", DW'(dv1[0]), DW'(1'b0));
      end
    end

    // Reset with reads in flight, then reset again partway through CLEAR.
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = AW'(3); wr_din[0 +: DW] = rep(32'hCAFE_0003); wr_mask[0 +: LN] = '1;
    step();
    idle();
    rd_valid[0] = 1'b1; rd_addr[0 +: AW] = AW'(3); rd_ocid[0 +: OW] = OW'(1);
    step();
    rd_ocid[0 +: OW] = OW'(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    chk("rst_flight_v1", DW'(dv1), '0);
    chk("rst_flight_v0", DW'(dv0), '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_clear_v1", DW'(dv1), '0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    idle();
    rd_valid[0] = 1'b1; rd_addr[0 +: AW] = AW'(3);
    step();
    chk("rst_data_cleared", dout0[0 +: DW], '0);

    // Traffic during CLEAR must be ignored.
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_valid = '1;
      wr_en = '1;
      wr_mask = '1;
      for (int b = 0; b < NB; b++) begin
        rd_addr[b*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        wr_addr[b*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        for (int l = 0; l < LN; l++) wr_din[b*DW + l*32 +: 32] = $urandom;
      end
      step();
      chk("clr_act_v0", DW'(dv0), '0);
    end
    read_all_zero("clr_act_zero");

    // Randomized traffic against the model; narrow addresses hit the bypass.
    for (int i = 0; i < 400; i++) begin
      rd_valid = NB'($urandom);
      wr_en = NB'($urandom);
      wr_mask = (NB*LN)'({$urandom, $urandom} & {$urandom, $urandom} | {$urandom, 32'h0});
      for (int b = 0; b < NB; b++) begin
        rd_addr[b*AW +: AW] = AW'($urandom_range(0, 3));
        wr_addr[b*AW +: AW] = AW'($urandom_range(0, 3));
        rd_ocid[b*OW +: OW] = OW'($urandom);
        for (int l = 0; l < LN; l++) wr_din[b*DW + l*32 +: 32] = $urandom;
      end
      step();
    end
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
